// File: rtl/div_seq_unit.sv
// div_seq_unit: multi-cycle RV32M divide sequencer (DIV, DIVU, REM, REMU).
// Runs radix-2 restoring division, one quotient bit per cycle, on operand
// magnitudes. A sign fix-up cycle follows. Divide-by-zero and signed overflow
// complete on a fast path.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       divide requested in EX (held while stall_o is high)
//   funct3      100 DIV, 101 DIVU, 110 REM, 111 REMU; funct3[2]=0 is ignored
//   op_a, op_b  dividend / divisor, captured at accept only
//   kill        synchronous abort (pipeline flush)
//   stall_o     freeze IF/EX registers
//   busy        state is not IDLE
//   done        one-cycle pulse, result valid in this cycle
//   result      registered quotient or remainder
module div_seq_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             kill,
  output logic             stall_o,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {StIdle, StCalc, StFin, StDone} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] count_q;
  logic             is_rem_q;   // select remainder instead of quotient
  logic             neg_quo_q;  // operand signs differ (signed ops only)
  logic             neg_rem_q;  // dividend negative (signed ops only)
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;      // holds dividend magnitude, shifted out as quotient shifts in
  logic [WIDTH-1:0] div_q;      // divisor magnitude
  logic [WIDTH-1:0] result_q;
  logic             done_q;

  logic             accept;
  logic             is_signed_in;
  logic             is_rem_in;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             div_zero;
  logic             sgn_ovf;
  logic [WIDTH-1:0] fast_res;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH+1:0] diff;
  logic             borrow;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  always_comb begin
    accept       = start & funct3[2] & (state_q == StIdle) & ~kill;
    is_signed_in = ~funct3[0];
    is_rem_in    = funct3[1];
    a_neg        = is_signed_in & op_a[WIDTH-1];
    b_neg        = is_signed_in & op_b[WIDTH-1];
    // Negating -2^(WIDTH-1) yields itself, which reads correctly as unsigned.
    a_mag        = a_neg ? (~op_a + 1'b1) : op_a;
    b_mag        = b_neg ? (~op_b + 1'b1) : op_b;
    div_zero     = (op_b == '0);
    sgn_ovf      = is_signed_in & (op_a == {1'b1, {(WIDTH-1){1'b0}}}) & (&op_b);
    if (div_zero) begin
      fast_res = is_rem_in ? op_a : '1;
    end else begin
      fast_res = is_rem_in ? '0 : op_a;
    end

    rem_shift = {rem_q, quo_q[WIDTH-1]};
    diff      = {1'b0, rem_shift} - {2'b00, div_q};
    borrow    = diff[WIDTH+1];

    quo_fix = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
    rem_fix = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      count_q   <= '0;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      rem_q     <= '0;
      quo_q     <= '0;
      div_q     <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            is_rem_q  <= is_rem_in;
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            rem_q     <= '0;
            quo_q     <= a_mag;
            div_q     <= b_mag;
            count_q   <= '0;
            if (div_zero || sgn_ovf) begin
              result_q <= fast_res;
              done_q   <= 1'b1;
              state_q  <= StDone;
            end else begin
              state_q <= StCalc;
            end
          end
        end
        StCalc: begin
          if (kill) begin
            state_q <= StIdle;
          end else begin
            if (borrow) begin
              rem_q <= rem_shift[WIDTH-1:0];
              quo_q <= {quo_q[WIDTH-2:0], 1'b0};
            end else begin
              rem_q <= diff[WIDTH-1:0];
              quo_q <= {quo_q[WIDTH-2:0], 1'b1};
            end
            count_q <= count_q + CNT_W'(1);
            if (count_q == CNT_W'(WIDTH - 1)) begin
              state_q <= StFin;
            end
          end
        end
        StFin: begin
          if (kill) begin
            state_q <= StIdle;
          end else begin
            result_q <= is_rem_q ? rem_fix : quo_fix;
            done_q   <= 1'b1;
            state_q  <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign stall_o = accept | (state_q == StCalc) | (state_q == StFin);
  assign busy    = (state_q != StIdle);
  assign done    = done_q;
  assign result  = result_q;

endmodule

// File: tb/tb_div_seq_unit.sv
module tb_div_seq_unit;

  localparam int unsigned W = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [2:0]   funct3;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         kill;
  logic         stall_o;
  logic         busy;
  logic         done;
  logic [W-1:0] result;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_res;

  div_seq_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .kill   (kill),
    .stall_o(stall_o),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest queued result.
  always @(negedge clk) begin
    if (rst_n && done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got result 0x%08h expected no done", result);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (result !== e) begin
          errors++;
          $display("FAIL result: got 0x%08h expected 0x%08h", result, e);
        end
      end
    end
  end

  // Issue one op at posedge+1; lat is edges until done (accept edge counts as 1).
  task automatic run_op(input string name, input logic [2:0] f3, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp, input int lat);
    int n;
    int st;
    start  = 1'b1;
    funct3 = f3;
    op_a   = a;
    op_b   = b;
    exp_q.push_back(exp);
    last_res = exp;
    #1;
    check({name, "_stall_at_accept"}, W'(stall_o), W'(1));
    n  = 0;
    st = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) begin
        op_a = 32'hDEAD_BEEF;
        op_b = 32'h0000_0001;
      end
      if (!done && stall_o) st++;
    end while (!done && n < 100);
    check({name, "_latency"}, W'(n), W'(lat));
    check({name, "_stall_cycles"}, W'(st), W'(lat - 1));
    check({name, "_stall_in_done"}, W'(stall_o), W'(0));
    start = 1'b0;
    @(posedge clk);
    #1;
    check({name, "_idle_after"}, W'(busy), W'(0));
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    funct3 = 3'b000;
    op_a   = '0;
    op_b   = '0;
    kill   = 1'b0;
    last_res = '0;
    #12;
    check("rst_busy", W'(busy), W'(0));
    check("rst_done", W'(done), W'(0));
    check("rst_stall", W'(stall_o), W'(0));
    check("rst_result", result, '0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op("divu_100_7", 3'b101, 32'd100, 32'd7, 32'd14, 34);
    run_op("remu_100_7", 3'b111, 32'd100, 32'd7, 32'd2, 34);
    run_op("div_m7_2",   3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    run_op("rem_m7_2",   3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    run_op("rem_7_m2",   3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1, 34);
    run_op("divu_55_0",  3'b101, 32'd55, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("rem_55_0",   3'b110, 32'd55, 32'd0, 32'd55, 1);
    run_op("div_ovf",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    run_op("divu_big",   3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34);

    // Kill at iteration 10: no done, result keeps its last value.
    start  = 1'b1;
    funct3 = 3'b101;
    op_a   = 32'd1000;
    op_b   = 32'd3;
    repeat (11) @(posedge clk);
    #1;
    check("kill_pre_busy", W'(busy), W'(1));
    start = 1'b0;
    kill  = 1'b1;
    @(posedge clk);
    #1;
    check("kill_busy", W'(busy), W'(0));
    check("kill_done", W'(done), W'(0));
    check("kill_result", result, last_res);
    kill = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    run_op("divu_9_3", 3'b101, 32'd9, 32'd3, 32'd3, 34);

    // kill together with start in IDLE suppresses accept.
    start = 1'b1;
    kill  = 1'b1;
    funct3 = 3'b101;
    #1;
    check("kill_start_stall", W'(stall_o), W'(0));
    @(posedge clk);
    #1;
    check("kill_start_busy", W'(busy), W'(0));
    start = 1'b0;
    kill  = 1'b0;

    // Reset mid-CALC.
    start  = 1'b1;
    funct3 = 3'b101;
    op_a   = 32'd100;
    op_b   = 32'd7;
    repeat (6) @(posedge clk);
    #1;
    start = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", W'(busy), W'(0));
    check("midrst_stall", W'(stall_o), W'(0));
    check("midrst_done", W'(done), W'(0));
    check("midrst_result", result, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // funct3[2]=0 is not a divide.
    start  = 1'b1;
    funct3 = 3'b000;
    #1;
    check("nondiv_stall", W'(stall_o), W'(0));
    @(posedge clk);
    #1;
    check("nondiv_busy", W'(busy), W'(0));
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
